// File: rtl/fir_pkg.sv
// Shared types and defaults for the stereo FIR equalizer sequencer.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, RUN, DRAIN} fir_seq_state_t;

  localparam int NUM_FILTERS_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT      = 8;

  // Keeps select ports at least one bit wide for a single-filter bank.
  function automatic int filt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FILT_W = filt_width(NUM_FILTERS_DEFAULT);

endpackage

// File: rtl/fir_strobe_delay.sv
// Delays the RUN-cycle MAC flags and filter index by the buffer/coefficient read latency.
module fir_strobe_delay
  import fir_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int W      = 3 + FILT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (RD_LAT == 0) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset_n, flush};
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] pipe [RD_LAT];

    always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
        for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign q = pipe[RD_LAT-1];
  end

endmodule

// File: rtl/fir_sequencer.sv
// Per-sample scheduler: writes the new L/R pair, then walks every filter and tap,
// generating buffer/coefficient addresses, MAC strobes and result flags.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_FILTERS = NUM_FILTERS_DEFAULT,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int RD_LAT      = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 audio_en,
  input  logic                                 sample_valid,
  input  logic [7:0]                           taps_per_filter,
  input  logic                                 overrun_clr,
  output logic                                 buf_we,
  output logic [ADDR_W-1:0]                    buf_wr_addr,
  output logic [ADDR_W-1:0]                    buf_rd_addr,
  output logic [filt_width(NUM_FILTERS)-1:0]   coef_filter,
  output logic [7:0]                           coef_tap,
  output logic                                 mac_clr,
  output logic                                 mac_en,
  output logic                                 mac_last,
  output logic                                 result_valid,
  output logic [filt_width(NUM_FILTERS)-1:0]   result_filter,
  output logic                                 busy,
  output logic                                 overrun
);

  localparam int              FW         = filt_width(NUM_FILTERS);
  localparam logic [FW-1:0]   LAST_FILT  = FW'(NUM_FILTERS - 1);
  localparam logic [7:0]      DRAIN_LAST = 8'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  fir_seq_state_t state, next_state;

  logic [ADDR_W-1:0] wptr, newest;
  logic [7:0]        taps_q, tap, drain_cnt;
  logic [FW-1:0]     filt, mac_filt;
  logic              tap_last, filt_last;
  logic              run_en, run_clr, run_last;
  logic              flush;
  logic [FW+2:0]     strobe_d, strobe_q;

  assign tap_last  = (tap == taps_q - 8'd1);
  assign filt_last = (filt == LAST_FILT);
  assign flush     = !audio_en;

  always_ff @(posedge clk) begin
    if (!reset_n || !audio_en) state <= IDLE;
    else                       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_valid) next_state = WRITE;
      WRITE:   next_state = (taps_q == 8'd0) ? IDLE : RUN;
      RUN:     if (tap_last && filt_last) next_state = (RD_LAT == 0) ? IDLE : DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    buf_we      = 1'b0;
    buf_rd_addr = '0;
    coef_filter = '0;
    coef_tap    = '0;
    run_en      = 1'b0;
    run_clr     = 1'b0;
    run_last    = 1'b0;
    busy        = (state != IDLE);
    case (state)
      WRITE: buf_we = 1'b1;
      RUN: begin
        buf_rd_addr = newest - ADDR_W'(tap);
        coef_filter = filt;
        coef_tap    = tap;
        run_en      = 1'b1;
        run_clr     = (tap == 8'd0);
        run_last    = tap_last;
      end
      default: ;
    endcase
  end

  assign buf_wr_addr = wptr;

  // Pointers and counters; an abort rewinds the write pointer so the buffers restart clean.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr      <= '0;
      newest    <= '0;
      taps_q    <= '0;
      tap       <= '0;
      filt      <= '0;
      drain_cnt <= '0;
    end else if (!audio_en) begin
      wptr      <= '0;
      tap       <= '0;
      filt      <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (sample_valid) taps_q <= taps_per_filter;
        WRITE: begin
          newest    <= wptr;
          wptr      <= wptr + ADDR_W'(1);
          tap       <= '0;
          filt      <= '0;
          drain_cnt <= '0;
        end
        RUN: begin
          if (tap_last) begin
            tap  <= '0;
            filt <= filt + FW'(1);
          end else begin
            tap <= tap + 8'd1;
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // A late sample is dropped; a new event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n)                                     overrun <= 1'b0;
    else if (audio_en && sample_valid && busy)        overrun <= 1'b1;
    else if (overrun_clr)                             overrun <= 1'b0;
  end

  assign strobe_d = {run_en, run_clr, run_last, coef_filter};

  fir_strobe_delay #(
    .RD_LAT (RD_LAT),
    .W      (FW + 3)
  ) u_strobe_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .d       (strobe_d),
    .q       (strobe_q)
  );

  assign {mac_en, mac_clr, mac_last} = strobe_q[FW+2:FW];
  assign mac_filt                    = strobe_q[FW-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n || !audio_en) begin
      result_valid  <= 1'b0;
      result_filter <= '0;
    end else begin
      result_valid <= mac_last;
      if (mac_last) result_filter <= mac_filt;
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// Directed bench for fir_sequencer: a per-cycle vector table plus multi-cycle scenarios,
// driving an RD_LAT=1 instance and an RD_LAT=0 instance from the same stimulus.
module tb_fir_sequencer;

  logic       clk = 1'b0;
  logic       reset_n, audio_en, sample_valid, overrun_clr;
  logic [7:0] taps_per_filter;

  logic       buf_we, mac_clr, mac_en, mac_last, result_valid, busy, overrun;
  logic [7:0] buf_wr_addr, buf_rd_addr, coef_tap;
  logic [1:0] coef_filter, result_filter;

  logic       l0_buf_we, l0_mac_clr, l0_mac_en, l0_mac_last, l0_result_valid, l0_busy, l0_overrun;
  logic [7:0] l0_buf_wr_addr, l0_buf_rd_addr, l0_coef_tap;
  logic [1:0] l0_coef_filter, l0_result_filter;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fir_sequencer #(.NUM_FILTERS(4), .ADDR_W(8), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n), .audio_en(audio_en), .sample_valid(sample_valid),
    .taps_per_filter(taps_per_filter), .overrun_clr(overrun_clr),
    .buf_we(buf_we), .buf_wr_addr(buf_wr_addr), .buf_rd_addr(buf_rd_addr),
    .coef_filter(coef_filter), .coef_tap(coef_tap), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_last(mac_last), .result_valid(result_valid), .result_filter(result_filter),
    .busy(busy), .overrun(overrun)
  );

  fir_sequencer #(.NUM_FILTERS(4), .ADDR_W(8), .RD_LAT(0)) dut_lat0 (
    .clk(clk), .reset_n(reset_n), .audio_en(audio_en), .sample_valid(sample_valid),
    .taps_per_filter(taps_per_filter), .overrun_clr(overrun_clr),
    .buf_we(l0_buf_we), .buf_wr_addr(l0_buf_wr_addr), .buf_rd_addr(l0_buf_rd_addr),
    .coef_filter(l0_coef_filter), .coef_tap(l0_coef_tap), .mac_clr(l0_mac_clr), .mac_en(l0_mac_en),
    .mac_last(l0_mac_last), .result_valid(l0_result_valid), .result_filter(l0_result_filter),
    .busy(l0_busy), .overrun(l0_overrun)
  );

  typedef struct {
    logic       sv;
    logic [7:0] taps;
    logic       oclr;
    logic       we;
    logic [7:0] wa;
    logic [7:0] rd;
    logic [1:0] cf;
    logic       busy;
    logic       en;
    logic       clr;
    logic       last;
    logic       rv;
    logic [1:0] rf;
    logic       ovr;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input int sv, input int taps, input int oclr, input int we,
                              input int wa, input int rd, input int cf, input int bsy,
                              input int en, input int clr, input int last, input int rv,
                              input int rf, input int ovr);
    vec_t v;
    v.sv = 1'(sv);   v.taps = 8'(taps); v.oclr = 1'(oclr); v.we = 1'(we);
    v.wa = 8'(wa);   v.rd = 8'(rd);     v.cf = 2'(cf);     v.busy = 1'(bsy);
    v.en = 1'(en);   v.clr = 1'(clr);   v.last = 1'(last); v.rv = 1'(rv);
    v.rf = 2'(rf);   v.ovr = 1'(ovr);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sample_valid    = v.sv;
    taps_per_filter = v.taps;
    overrun_clr     = v.oclr;
    tick();
  endtask

  task automatic doReset();
    reset_n = 1'b0; audio_en = 1'b1; sample_valid = 1'b0; overrun_clr = 1'b0;
    taps_per_filter = 8'd0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  int en_cnt, l0_en_cnt, rv_cnt, last_busy, l0_last_busy, l0_first_en, l0_first_rv, n_clr, n_rv;
  int clr_cyc [4];
  int rv_cyc [4];
  int rv_filt [4];
  int exp_cyc;

  initial begin
    vecs[0]  = mk(1,1,0, 1,0,0,0,1,0,0,0,0,0,0);
    vecs[1]  = mk(0,0,0, 0,1,0,0,1,0,0,0,0,0,0);
    vecs[2]  = mk(0,0,0, 0,1,0,1,1,1,1,1,0,0,0);
    vecs[3]  = mk(0,0,0, 0,1,0,2,1,1,1,1,1,0,0);
    vecs[4]  = mk(0,0,0, 0,1,0,3,1,1,1,1,1,1,0);
    vecs[5]  = mk(0,0,0, 0,1,0,0,1,1,1,1,1,2,0);
    vecs[6]  = mk(0,0,0, 0,1,0,0,0,0,0,0,1,3,0);
    vecs[7]  = mk(0,0,0, 0,1,0,0,0,0,0,0,0,0,0);
    vecs[8]  = mk(1,0,0, 1,1,0,0,1,0,0,0,0,0,0);
    vecs[9]  = mk(0,0,0, 0,2,0,0,0,0,0,0,0,0,0);
    vecs[10] = mk(0,0,0, 0,2,0,0,0,0,0,0,0,0,0);
    vecs[11] = mk(1,2,0, 1,2,0,0,1,0,0,0,0,0,0);
    vecs[12] = mk(0,0,0, 0,3,2,0,1,0,0,0,0,0,0);
    vecs[13] = mk(0,5,0, 0,3,1,0,1,1,1,0,0,0,0);
    vecs[14] = mk(0,0,0, 0,3,2,1,1,1,0,1,0,0,0);
    vecs[15] = mk(1,0,0, 0,3,1,1,1,1,1,0,1,0,1);
    vecs[16] = mk(0,0,0, 0,3,2,2,1,1,0,1,0,0,1);
    vecs[17] = mk(0,0,0, 0,3,1,2,1,1,1,0,1,1,1);
    vecs[18] = mk(0,0,0, 0,3,2,3,1,1,0,1,0,0,1);
    vecs[19] = mk(0,0,0, 0,3,1,3,1,1,1,0,1,2,1);
    vecs[20] = mk(0,0,0, 0,3,0,0,1,1,0,1,0,0,1);
    vecs[21] = mk(0,0,1, 0,3,0,0,0,0,0,0,1,3,0);

    // Reset state, sampled while reset_n is still low.
    reset_n = 1'b0; audio_en = 1'b1; sample_valid = 1'b0; overrun_clr = 1'b0;
    taps_per_filter = 8'd0;
    tick();
    tick();
    checkOutput("reset buf_we",       32'(buf_we),       0);
    checkOutput("reset buf_wr_addr",  32'(buf_wr_addr),  0);
    checkOutput("reset buf_rd_addr",  32'(buf_rd_addr),  0);
    checkOutput("reset mac_en",       32'(mac_en),       0);
    checkOutput("reset mac_clr",      32'(mac_clr),      0);
    checkOutput("reset mac_last",     32'(mac_last),     0);
    checkOutput("reset result_valid", 32'(result_valid), 0);
    checkOutput("reset busy",         32'(busy),         0);
    checkOutput("reset overrun",      32'(overrun),      0);
    reset_n = 1'b1;

    // Table: taps=1, taps=0, then taps=2 with a mid-run taps change, overrun and clear.
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d buf_we", i),      32'(buf_we),      32'(vecs[i].we));
      checkOutput($sformatf("v%0d buf_wr_addr", i), 32'(buf_wr_addr), 32'(vecs[i].wa));
      checkOutput($sformatf("v%0d buf_rd_addr", i), 32'(buf_rd_addr), 32'(vecs[i].rd));
      checkOutput($sformatf("v%0d coef_filter", i), 32'(coef_filter), 32'(vecs[i].cf));
      checkOutput($sformatf("v%0d busy", i),        32'(busy),        32'(vecs[i].busy));
      checkOutput($sformatf("v%0d mac_en", i),      32'(mac_en),      32'(vecs[i].en));
      checkOutput($sformatf("v%0d mac_clr", i),     32'(mac_clr),     32'(vecs[i].clr));
      checkOutput($sformatf("v%0d mac_last", i),    32'(mac_last),    32'(vecs[i].last));
      checkOutput($sformatf("v%0d result_valid", i), 32'(result_valid), 32'(vecs[i].rv));
      if (vecs[i].rv)
        checkOutput($sformatf("v%0d result_filter", i), 32'(result_filter), 32'(vecs[i].rf));
      checkOutput($sformatf("v%0d overrun", i),     32'(overrun),     32'(vecs[i].ovr));
    end
    sample_valid = 1'b0; overrun_clr = 1'b0;

    // Single sample, taps=8: cycle c counts from the sample_valid cycle.
    doReset();
    sample_valid = 1'b1; taps_per_filter = 8'd8;
    en_cnt = 0; l0_en_cnt = 0; n_clr = 0; n_rv = 0; last_busy = -1; l0_last_busy = -1;
    l0_first_en = -1; l0_first_rv = -1;
    for (int k = 0; k < 4; k++) begin clr_cyc[k] = -1; rv_cyc[k] = -1; rv_filt[k] = -1; end
    tick();
    sample_valid = 1'b0;
    checkOutput("t8 buf_we at T+1",      32'(buf_we),      1);
    checkOutput("t8 buf_wr_addr at T+1", 32'(buf_wr_addr), 0);
    for (int c = 1; c <= 45; c++) begin
      if (c == 2) begin
        checkOutput("t8 lat1 mac_en at T+2", 32'(mac_en), 0);
        checkOutput("t8 lat0 mac_en at T+2", 32'(l0_mac_en), 1);
        checkOutput("t8 lat0 rd_addr at T+2", 32'(l0_buf_rd_addr), 0);
      end
      if (mac_en) en_cnt++;
      if (l0_mac_en) begin
        l0_en_cnt++;
        if (l0_first_en < 0) l0_first_en = c;
      end
      if (mac_clr) begin
        if (n_clr < 4) clr_cyc[n_clr] = c;
        n_clr++;
      end
      if (result_valid) begin
        if (n_rv < 4) begin rv_cyc[n_rv] = c; rv_filt[n_rv] = int'(result_filter); end
        n_rv++;
      end
      if (l0_result_valid && l0_first_rv < 0) l0_first_rv = c;
      if (busy) last_busy = c;
      if (l0_busy) l0_last_busy = c;
      tick();
    end
    checkOutput("t8 mac_en count", en_cnt, 32);
    checkOutput("t8 mac_clr count", n_clr, 4);
    checkOutput("t8 result_valid count", n_rv, 4);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t8 mac_clr cycle %0d", k), clr_cyc[k], 3 + 8 * k);
      checkOutput($sformatf("t8 result_valid cycle %0d", k), rv_cyc[k], 11 + 8 * k);
      checkOutput($sformatf("t8 result_filter %0d", k), rv_filt[k], k);
    end
    checkOutput("t8 last busy cycle", last_busy, 34);
    checkOutput("t8 lat0 mac_en count", l0_en_cnt, 32);
    checkOutput("t8 lat0 first mac_en", l0_first_en, 2);
    checkOutput("t8 lat0 first result_valid", l0_first_rv, 10);
    checkOutput("t8 lat0 last busy cycle", l0_last_busy, 33);

    // Wrap-around: three taps=0 samples move the write pointer to 3, then taps=6.
    doReset();
    for (int k = 0; k < 3; k++) begin
      sample_valid = 1'b1; taps_per_filter = 8'd0;
      tick();
      sample_valid = 1'b0;
      tick();
    end
    sample_valid = 1'b1; taps_per_filter = 8'd6;
    tick();
    sample_valid = 1'b0;
    checkOutput("wrap buf_we", 32'(buf_we), 1);
    checkOutput("wrap buf_wr_addr", 32'(buf_wr_addr), 3);
    tick();
    for (int i = 0; i < 24; i++) begin
      exp_cyc = (3 - (i % 6)) & 255;
      checkOutput($sformatf("wrap rd_addr step %0d", i), 32'(buf_rd_addr), exp_cyc);
      checkOutput($sformatf("wrap coef_tap step %0d", i), 32'(coef_tap), i % 6);
      checkOutput($sformatf("wrap coef_filter step %0d", i), 32'(coef_filter), i / 6);
      tick();
    end
    for (int i = 0; i < 4; i++) tick();

    // Overrun: taps=255 with a second sample 100 cycles in.
    doReset();
    sample_valid = 1'b1; taps_per_filter = 8'd255;
    tick();
    sample_valid = 1'b0;
    en_cnt = 0; rv_cnt = 0; last_busy = -1; l0_last_busy = -1;
    for (int c = 1; c <= 1100; c++) begin
      if (c == 101) checkOutput("ovr flag after late sample", 32'(overrun), 1);
      if (mac_en) en_cnt++;
      if (result_valid) rv_cnt++;
      if (busy) last_busy = c;
      if (l0_busy) l0_last_busy = c;
      sample_valid = (c == 100);
      tick();
    end
    sample_valid = 1'b0;
    checkOutput("ovr flag sticky", 32'(overrun), 1);
    checkOutput("ovr wptr advanced once", 32'(buf_wr_addr), 1);
    checkOutput("ovr mac_en count", en_cnt, 1020);
    checkOutput("ovr result_valid count", rv_cnt, 4);
    checkOutput("ovr last busy cycle", last_busy, 1022);
    checkOutput("ovr lat0 last busy cycle", l0_last_busy, 1021);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checkOutput("ovr cleared", 32'(overrun), 0);
    sample_valid = 1'b1; taps_per_filter = 8'd2;
    tick();
    overrun_clr = 1'b1;
    tick();
    sample_valid = 1'b0; overrun_clr = 1'b0;
    checkOutput("ovr set beats clear", 32'(overrun), 1);
    for (int i = 0; i < 15; i++) tick();

    // Abort mid-RUN while filter 2 is active, with overrun already set.
    doReset();
    sample_valid = 1'b1; taps_per_filter = 8'd4;
    tick();
    for (int c = 1; c < 11; c++) begin
      sample_valid = (c == 3);
      tick();
    end
    checkOutput("abort coef_filter before", 32'(coef_filter), 2);
    checkOutput("abort overrun before", 32'(overrun), 1);
    audio_en = 1'b0;
    tick();
    checkOutput("abort busy", 32'(busy), 0);
    checkOutput("abort buf_we", 32'(buf_we), 0);
    checkOutput("abort buf_wr_addr", 32'(buf_wr_addr), 0);
    checkOutput("abort mac strobes", 32'({mac_en, mac_clr, mac_last}), 0);
    checkOutput("abort result_valid", 32'(result_valid), 0);
    checkOutput("abort overrun kept", 32'(overrun), 1);
    checkOutput("abort lat0 mac strobes", 32'({l0_mac_en, l0_mac_clr, l0_mac_last}), 0);
    checkOutput("abort lat0 busy", 32'(l0_busy), 0);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    checkOutput("abort sample ignored busy", 32'(busy), 0);
    checkOutput("abort sample ignored wptr", 32'(buf_wr_addr), 0);
    audio_en = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (result_valid || mac_en || busy) rv_cnt++;
      tick();
    end
    checkOutput("abort pipeline flushed", rv_cnt, 0);
    reset_n = 1'b0;
    tick();
    checkOutput("reset clears overrun", 32'(overrun), 0);
    reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Control sequencer for the stereo FIR equalizer bank. On each stereo sample strobe it writes the new L/R sample pair into the shared circular sample buffers, then walks all filters and taps. For each step it drives the buffer read address, the coefficient address and the MAC strobes (clear/enable/last), and flags each finished filter result. It sits between the I2S receive path (sample strobe) and the buffer RAMs, coefficient RAMs and tap MACs. It replaces ad-hoc counter logic with one scheduler that owns all address generation.

## Interface
Parameters:
- NUM_FILTERS, 4, filters in the bank, evaluated sequentially on the shared data path
- ADDR_W, 8, circular buffer address width (depth 2^ADDR_W)
- RD_LAT, 1, cycles from address to data at MAC inputs; 0 allowed

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- audio_en  in  1  low = synchronous abort/hold in IDLE
- sample_valid  in  1  one-cycle strobe: new L/R pair present on buffer data inputs
- taps_per_filter  in  8  taps per filter, latched at sequence start
- overrun_clr  in  1  clears overrun flag
- buf_we  out  1  write strobe to L and R circular buffers
- buf_wr_addr  out  ADDR_W  write address (write pointer)
- buf_rd_addr  out  ADDR_W  read address for both buffers
- coef_filter  out  $clog2(NUM_FILTERS)  coefficient RAM filter select
- coef_tap  out  8  coefficient RAM tap address
- mac_clr  out  1  load accumulator with first product (tap 0)
- mac_en  out  1  accumulate product this cycle
- mac_last  out  1  final tap of current filter
- result_valid  out  1  accumulator holds finished filter result
- result_filter  out  $clog2(NUM_FILTERS)  index of filter in result_valid
- busy  out  1  sequence in progress
- overrun  out  1  sticky: sample arrived while busy

## Operation
- States: IDLE, WRITE, RUN, DRAIN.
- IDLE: on sample_valid go to WRITE. Latch taps_per_filter into taps_q. Set busy.
- WRITE (1 cycle): buf_we=1, buf_wr_addr=wptr. Record newest=wptr, then wptr<=wptr+1. If taps_q==0, return to IDLE; no MAC strobes, no result_valid. Otherwise go to RUN with filt=0, tap=0.
- RUN, one cycle per tap:
  - buf_rd_addr=newest-tap (mod 2^ADDR_W); coef_filter=filt; coef_tap=tap.
  - tap==taps_q-1 ends the filter: tap<=0, filt<=filt+1.
  - Last tap of filter NUM_FILTERS-1 goes to DRAIN.
- DRAIN: RD_LAT cycles (skipped when RD_LAT=0), then IDLE, busy low.
- MAC strobes are the RUN-cycle flags delayed by RD_LAT:
  - mac_en on every tap.
  - mac_clr on tap 0.
  - mac_last on tap taps_q-1.
  - mac_clr and mac_last are both high when taps_q==1.
- result_valid: one cycle after each mac_last. result_filter is the filter index delayed to match.
- Wrap-around: all buffer addresses wrap mod 2^ADDR_W. taps_q > 2^ADDR_W reads aliased samples; this is the user's responsibility and is not detected.
- Overrun: sample_valid while busy sets overrun. The sample is not written and the sequence continues unchanged. overrun_clr clears the flag; if set and clear occur in the same cycle, set wins.
- audio_en low: next cycle state=IDLE, wptr=0, all strobes low, busy low, pipeline flushed. overrun is kept. sample_valid is ignored while audio_en is low.
- reset_n low: all registers 0. All outputs read 0, including overrun.

## Timing
- Latency from sample_valid at cycle T:
  - buf_we at T+1.
  - First RUN address at T+2.
  - First mac_en at T+2+RD_LAT.
- Filter f's mac_last falls at T+2+RD_LAT+(f+1)*taps_q-1; its result_valid falls one cycle later.
- busy is high T+1 through T+1+NUM_FILTERS*taps_q+RD_LAT inclusive.
- Budget: 4×255 taps = 1020 cycles, well below a 48 kHz frame at 100 MHz. No back-pressure.
- A taps_per_filter change mid-sequence has no effect until the next sample.

## Structure
- Package fir_pkg holds:
  - state enum fir_seq_state_t {IDLE, WRITE, RUN, DRAIN}
  - NUM_FILTERS default
  - ADDR_W default
  - FILT_W = $clog2(NUM_FILTERS)
- Sub-module fir_strobe_delay: parameterized RD_LAT shift register for {mac_en, mac_clr, mac_last, filt}. Pass-through when RD_LAT=0. Instantiate once.

## Test plan
- Single sample: NUM_FILTERS=4, taps=8, RD_LAT=1, sample_valid at T.
  - buf_we at T+1 with buf_wr_addr=0.
  - 32 mac_en pulses.
  - mac_clr at taps 0, 8, 16, 24.
  - result_valid for filters 0..3 at T+11, T+19, T+27, T+35.
  - busy drops after T+34.
- Wrap-around: preload wptr to 3 via 3 samples, taps=6.
  - buf_rd_addr sequence 3,2,1,0,255,254 for each filter.
- Edge taps:
  - taps=1: mac_clr and mac_last coincide, 4 result_valid on consecutive cycles.
  - taps=0: single buf_we, no mac strobes, busy for 1 cycle.
- Overrun: taps=255, second sample_valid 100 cycles after the first.
  - overrun=1; wptr advances once; sequence completes normally.
  - overrun_clr together with a new overrun event leaves overrun=1.
- Abort: audio_en low mid-RUN (filt=2).
  - Next cycle: IDLE, all strobes 0, wptr=0, overrun retained.
  - reset_n low clears overrun.
- RD_LAT=0 build: mac_en is coincident with the first RUN address at T+2; no DRAIN cycle.
